// File: rtl/interrupt_controller.sv
// Multi-channel interrupt front end for the 9x8 core: synchronises N_CH lines,
// latches pending events, masks them and hands one channel at a time to the core.
module interrupt_controller #(
    parameter int                N_CH        = 4,
    parameter int                SYNC_STAGES = 2,
    parameter logic [N_CH-1:0]   EDGE_MODE   = {N_CH{1'b1}},
    parameter logic [N_CH-1:0]   MASK_INIT   = {N_CH{1'b1}},
    localparam int               VW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            s_clk,
    input  logic            s_rst,
    input  logic [N_CH-1:0] i_irq,
    input  logic            i_mask_wr,
    input  logic [N_CH-1:0] i_mask_data,
    input  logic            i_pend_clr,
    input  logic [N_CH-1:0] i_pend_clr_data,
    output logic            o_int,
    input  logic            i_int_ack,
    input  logic            i_int_done,
    output logic [VW-1:0]   o_vector,
    output logic [N_CH-1:0] o_pending,
    output logic [N_CH-1:0] o_mask
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_BUSY
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0] sy, prev, rise;
    logic [N_CH-1:0] pending, pending_n, mask, eligible;
    logic [N_CH-1:0] ack_clr, sw_clr;
    logic [VW-1:0]   prio_idx, vector_n;
    logic            int_n;

    assign sy       = sync_q[SYNC_STAGES-1];
    assign rise     = sy & ~prev;
    assign eligible = pending & mask;
    assign sw_clr   = i_pend_clr ? i_pend_clr_data : '0;

    // NOTE: every flop is on the async reset, including the synchroniser chain,
    // so a reset mid-request leaves no stale edge that could re-fire afterwards.
    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            sync_q <= '0;
            prev   <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the old value of
            // the one before it; blocking here would collapse the chain to one flop.
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_irq};
            prev   <= sy;
        end
    end

    // Lowest index wins: scan downwards so the last hit is the smallest channel.
    always_comb begin
        prio_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (eligible[i]) prio_idx = VW'(i);
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned, which would otherwise infer a latch.
        state_n  = state;
        vector_n = o_vector;
        ack_clr  = '0;
        case (state)
            ST_IDLE: begin
                if (|eligible) begin
                    state_n  = ST_REQ;
                    vector_n = prio_idx;
                end
            end
            ST_REQ: begin
                // An ack in the same cycle as a clear still counts: the core has
                // already committed to servicing this vector.
                if (i_int_ack) begin
                    state_n           = ST_BUSY;
                    ack_clr[o_vector] = 1'b1;
                end else if (!eligible[o_vector]) begin
                    state_n = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (i_int_done) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        int_n = (state_n == ST_REQ);
    end

    // Edge channels: a new rising edge beats any clear in the same cycle.
    // Level channels simply mirror the synchronised line.
    assign pending_n = (EDGE_MODE & ((pending & ~(ack_clr | sw_clr)) | rise))
                     | (~EDGE_MODE & sy);

    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            state    <= ST_IDLE;
            o_int    <= 1'b0;
            o_vector <= '0;
            pending  <= '0;
            mask     <= MASK_INIT;
        end else begin
            state    <= state_n;
            o_int    <= int_n;
            o_vector <= vector_n;
            pending  <= pending_n;
            if (i_mask_wr) mask <= i_mask_data;
        end
    end

    assign o_pending = pending;
    assign o_mask    = mask;

endmodule
